// File: rtl/priority_encoder_req_if.sv
// Request/grant bundle for priority_encoder_req: request pulses in, granted index out over valid/ready.
// The slave modport is the encoder side; the master modport is the request sources plus consumer.
interface priority_encoder_req_if #(
    parameter int N_IN = 4
);
    localparam int OUT_W = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]  req_in;
    logic             out_ready;
    logic             out_valid;
    logic [OUT_W-1:0] out_code;
    logic [N_IN-1:0]  pending;
    logic [N_IN-1:0]  req_lost;
    logic             busy;

    modport slave (
        input  req_in,
        input  out_ready,
        output out_valid,
        output out_code,
        output pending,
        output req_lost,
        output busy
    );

    modport master (
        output req_in,
        output out_ready,
        input  out_valid,
        input  out_code,
        input  pending,
        input  req_lost,
        input  busy
    );
endinterface

// File: rtl/priority_encoder_req.sv
// Registered N_IN-to-index request encoder with sticky pending bits and a valid/ready output.
// Define ROUND_ROBIN_EN for rotating priority; otherwise the highest set index always wins.
module priority_encoder_req #(
    parameter int N_IN = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    priority_encoder_req_if.slave bus
);
    localparam int OUT_W = ($clog2(N_IN) > 1) ? $clog2(N_IN) : 1;

    logic [N_IN-1:0]  pending_q,  pending_d;
    logic [N_IN-1:0]  reqLost_q,  reqLost_d;
    logic             outValid_q, outValid_d;
    logic [OUT_W-1:0] outCode_q,  outCode_d;

    logic [N_IN-1:0]  cand;
    logic             anyCand;
    logic             slotFree;
    logic             grant;
    logic [OUT_W-1:0] winIdx;
    logic [N_IN-1:0]  winOh;

`ifdef ROUND_ROBIN_EN
    logic [OUT_W-1:0] ptr_q, ptr_d;

    // Walk from the pointer downward with wrap; the last hit written is the one nearest the pointer.
    always_comb begin
        winIdx = '0;
        for (int k = N_IN - 1; k >= 0; k--) begin
            int idx;
            idx = int'(ptr_q) - k;
            if (idx < 0) idx = idx + N_IN;
            if (cand[idx]) winIdx = OUT_W'(idx);
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant) ptr_d = (winIdx == '0) ? OUT_W'(N_IN - 1) : winIdx - OUT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= OUT_W'(N_IN - 1);
        else     ptr_q <= ptr_d;
    end
`else
    always_comb begin
        winIdx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (cand[i]) winIdx = OUT_W'(i);
        end
    end
`endif

    always_comb begin
        cand     = pending_q | bus.req_in;
        anyCand  = |cand;
        slotFree = !outValid_q || bus.out_ready;
        grant    = slotFree && anyCand;
        winOh    = anyCand ? (N_IN'(1) << winIdx) : '0;

        pending_d  = pending_q | bus.req_in;
        outValid_d = outValid_q;
        outCode_d  = outCode_q;
        if (slotFree) begin
            outValid_d = anyCand;
            pending_d  = cand & ~winOh;
            if (anyCand) outCode_d = winIdx;
        end

        // A request on the bit being granted right now is absorbed by that grant, not lost.
        reqLost_d = bus.req_in & pending_q & ~(grant ? winOh : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q  <= '0;
            reqLost_q  <= '0;
            outValid_q <= 1'b0;
            outCode_q  <= '0;
        end else begin
            pending_q  <= pending_d;
            reqLost_q  <= reqLost_d;
            outValid_q <= outValid_d;
            outCode_q  <= outCode_d;
        end
    end

    assign bus.out_valid = outValid_q;
    assign bus.out_code  = outCode_q;
    assign bus.pending   = pending_q;
    assign bus.req_lost  = reqLost_q;
    assign bus.busy      = (|pending_q) | outValid_q;
endmodule
